// File: rtl/disp_arbiter.sv
// Display arbiter: fixed-priority, preemptive sharing of the 4-digit display with a minimum hold.
// Define DISP_ARB_BLINK_EN to compile in the per-digit blink divider; otherwise disp_blank is tied low.
module disp_arbiter #(
    parameter int NREQ      = 4,
    parameter int MIN_HOLD  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [16*NREQ-1:0]   bcd_in,
    input  logic [4*NREQ-1:0]    blink_in,
    output logic [NREQ-1:0]      grant,
    output logic [15:0]          disp_bcd,
    output logic [3:0]           disp_blank,
    output logic                 switch_pulse
);

    localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;

    typedef enum logic [1:0] {S_BG, S_SHOW, S_HOLD} state_t;

    state_t            state_q, state_d;
    logic [OW-1:0]     owner_q, owner_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [15:0]       bcd_q, bcd_d;
    logic              pulse_q, pulse_d;
    logic [OW-1:0]     win;
    logic              any_req;

    always_comb begin
        win     = '0;
        any_req = 1'b0;
        for (int i = 1; i < NREQ; i++) begin
            if (req[i]) begin
                win     = OW'(i);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BG;
            owner_q <= '0;
            hold_q  <= '0;
            grant_q <= NREQ'(1);
            bcd_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            bcd_q   <= bcd_d;
            pulse_q <= pulse_d;
        end
    end

    // hold_d defaults to zero so leaving HOLD for any reason discards the count
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        hold_d  = '0;
        case (state_q)
            S_BG: begin
                if (any_req) begin
                    state_d = S_SHOW;
                    owner_d = win;
                end
            end
            S_SHOW: begin
                if (any_req && (win > owner_q)) begin
                    owner_d = win;
                end else if (!req[owner_q]) begin
                    if (MIN_HOLD == 0) begin
                        state_d = any_req ? S_SHOW : S_BG;
                        owner_d = any_req ? win : '0;
                    end else begin
                        state_d = S_HOLD;
                        hold_d  = HW'(MIN_HOLD - 1);
                    end
                end
            end
            S_HOLD: begin
                if (any_req && (win > owner_q)) begin
                    state_d = S_SHOW;
                    owner_d = win;
                end else if (req[owner_q]) begin
                    state_d = S_SHOW;
                end else if (hold_q == '0) begin
                    state_d = any_req ? S_SHOW : S_BG;
                    owner_d = any_req ? win : '0;
                end else begin
                    state_d = S_HOLD;
                    hold_d  = hold_q - HW'(1);
                end
            end
            default: begin
                state_d = S_BG;
                owner_d = '0;
            end
        endcase
    end

    always_comb begin
        grant_d          = '0;
        grant_d[owner_d] = 1'b1;
        bcd_d            = bcd_in[16*owner_d +: 16];
        pulse_d          = (owner_d != owner_q);
    end

    assign grant        = grant_q;
    assign disp_bcd     = bcd_q;
    assign switch_pulse = pulse_q;

`ifdef DISP_ARB_BLINK_EN
    localparam int DW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DW-1:0] div_q, div_d;
    logic          phase_q, phase_d;
    logic [3:0]    blank_q, blank_d;

    // An owner change restarts the blink visible so the newly shown digits are never dark on arrival
    always_comb begin
        div_d   = div_q + DW'(1);
        phase_d = phase_q;
        if (owner_d != owner_q) begin
            div_d   = '0;
            phase_d = 1'b0;
        end else if (div_q == DW'(BLINK_DIV - 1)) begin
            div_d   = '0;
            phase_d = ~phase_q;
        end
        blank_d = blink_in[4*owner_d +: 4] & {4{phase_d}};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            phase_q <= 1'b0;
            blank_q <= '0;
        end else begin
            div_q   <= div_d;
            phase_q <= phase_d;
            blank_q <= blank_d;
        end
    end

    assign disp_blank = blank_q;
`else
    logic unused_blink;
    assign unused_blink = ^blink_in;
    assign disp_blank   = 4'b0000;
`endif

endmodule

// File: tb/tb_disp_arbiter.sv
// Directed bench for disp_arbiter with MIN_HOLD=10 and BLINK_DIV=4.
// Blink expectations follow DISP_ARB_BLINK_EN as seen by this file.
module tb_disp_arbiter;

    localparam int NREQ = 4;

`ifdef DISP_ARB_BLINK_EN
    localparam logic [3:0] BL1 = 4'b0011;
    localparam logic [3:0] BL2 = 4'b1100;
`else
    localparam logic [3:0] BL1 = 4'b0000;
    localparam logic [3:0] BL2 = 4'b0000;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req;
    logic [16*NREQ-1:0]   bcd_in;
    logic [4*NREQ-1:0]    blink_in;
    logic [NREQ-1:0]      grant;
    logic [15:0]          disp_bcd;
    logic [3:0]           disp_blank;
    logic                 switch_pulse;

    int n_pass  = 0;
    int n_total = 0;

    disp_arbiter #(
        .NREQ      (NREQ),
        .MIN_HOLD  (10),
        .BLINK_DIV (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .bcd_in       (bcd_in),
        .blink_in     (blink_in),
        .grant        (grant),
        .disp_bcd     (disp_bcd),
        .disp_blank   (disp_blank),
        .switch_pulse (switch_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle;
        req = 4'b0000;
        repeat (12) tick();
    endtask

    task automatic test_reset;
        req = 4'b0010;
        tick();
        n_total++;
        if (grant !== 4'b0010) $display("FAIL rst_pre_grant got %b want %b", grant, 4'b0010); else n_pass++;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_total++;
        if (grant !== 4'b0001) $display("FAIL rst_grant got %b want %b", grant, 4'b0001); else n_pass++;
        n_total++;
        if (disp_bcd !== 16'h0000) $display("FAIL rst_bcd got %h want %h", disp_bcd, 16'h0000); else n_pass++;
        n_total++;
        if (disp_blank !== 4'b0000) $display("FAIL rst_blank got %b want %b", disp_blank, 4'b0000); else n_pass++;
        n_total++;
        if (switch_pulse !== 1'b0) $display("FAIL rst_pulse got %b want %b", switch_pulse, 1'b0); else n_pass++;
        req = 4'b0000;
        tick();
        n_total++;
        if (grant !== 4'b0001) $display("FAIL rst_held_grant got %b want %b", grant, 4'b0001); else n_pass++;
        reset = 1'b1;
        tick();
        n_total++;
        if (disp_bcd !== 16'h1234) $display("FAIL rst_rel_bcd got %h want %h", disp_bcd, 16'h1234); else n_pass++;
        n_total++;
        if (grant !== 4'b0001) $display("FAIL rst_rel_grant got %b want %b", grant, 4'b0001); else n_pass++;
        n_total++;
        if (switch_pulse !== 1'b0) $display("FAIL rst_rel_pulse got %b want %b", switch_pulse, 1'b0); else n_pass++;
    endtask

    task automatic test_reset_mid_hold;
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        tick();
        n_total++;
        if (grant !== 4'b0100) $display("FAIL rmh_inhold_grant got %b want %b", grant, 4'b0100); else n_pass++;
        reset = 1'b0;
        #1;
        n_total++;
        if (grant !== 4'b0001) $display("FAIL rmh_grant got %b want %b", grant, 4'b0001); else n_pass++;
        reset = 1'b1;
        tick();
        n_total++;
        if (switch_pulse !== 1'b0) $display("FAIL rmh_pulse got %b want %b", switch_pulse, 1'b0); else n_pass++;
        n_total++;
        if (grant !== 4'b0001) $display("FAIL rmh_after_grant got %b want %b", grant, 4'b0001); else n_pass++;
    endtask

    task automatic test_preemption;
        req = 4'b0010;
        tick();
        n_total++;
        if (grant !== 4'b0010) $display("FAIL pre_g1 got %b want %b", grant, 4'b0010); else n_pass++;
        n_total++;
        if (disp_bcd !== 16'h0105) $display("FAIL pre_bcd1 got %h want %h", disp_bcd, 16'h0105); else n_pass++;
        n_total++;
        if (switch_pulse !== 1'b1) $display("FAIL pre_pulse1 got %b want %b", switch_pulse, 1'b1); else n_pass++;
        tick();
        req = 4'b1010;
        tick();
        n_total++;
        if (grant !== 4'b1000) $display("FAIL pre_g3 got %b want %b", grant, 4'b1000); else n_pass++;
        n_total++;
        if (disp_bcd !== 16'h0700) $display("FAIL pre_bcd3 got %h want %h", disp_bcd, 16'h0700); else n_pass++;
        n_total++;
        if (switch_pulse !== 1'b1) $display("FAIL pre_pulse3 got %b want %b", switch_pulse, 1'b1); else n_pass++;
        tick();
        n_total++;
        if (switch_pulse !== 1'b0) $display("FAIL pre_pulse_once got %b want %b", switch_pulse, 1'b0); else n_pass++;
        n_total++;
        if (grant !== 4'b1000) $display("FAIL pre_g3_stay got %b want %b", grant, 4'b1000); else n_pass++;
        go_idle();
    endtask

    task automatic test_hold;
        req = 4'b0100;
        tick();
        tick();
        req = 4'b0010;
        tick();
        n_total++;
        if (grant !== 4'b0100 || switch_pulse !== 1'b0)
            $display("FAIL hold_k0 got %b/%b want 0100/0", grant, switch_pulse);
        else n_pass++;
        for (int k = 1; k <= 9; k++) begin
            tick();
            n_total++;
            if (grant !== 4'b0100 || switch_pulse !== 1'b0)
                $display("FAIL hold_k%0d got %b/%b want 0100/0", k, grant, switch_pulse);
            else n_pass++;
        end
        tick();
        n_total++;
        if (grant !== 4'b0010) $display("FAIL hold_end_grant got %b want %b", grant, 4'b0010); else n_pass++;
        n_total++;
        if (switch_pulse !== 1'b1) $display("FAIL hold_end_pulse got %b want %b", switch_pulse, 1'b1); else n_pass++;
        n_total++;
        if (disp_bcd !== 16'h0105) $display("FAIL hold_end_bcd got %h want %h", disp_bcd, 16'h0105); else n_pass++;
        tick();
        n_total++;
        if (switch_pulse !== 1'b0) $display("FAIL hold_pulse_once got %b want %b", switch_pulse, 1'b0); else n_pass++;
        go_idle();
    endtask

    task automatic test_reacquire;
        req = 4'b0100;
        tick();
        n_total++;
        if (switch_pulse !== 1'b1) $display("FAIL reacq_arrive_pulse got %b want %b", switch_pulse, 1'b1); else n_pass++;
        tick();
        req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (grant !== 4'b0100 || switch_pulse !== 1'b0)
                $display("FAIL reacq_drop%0d got %b/%b want 0100/0", k, grant, switch_pulse);
            else n_pass++;
        end
        req = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (grant !== 4'b0100 || switch_pulse !== 1'b0)
                $display("FAIL reacq_back%0d got %b/%b want 0100/0", k, grant, switch_pulse);
            else n_pass++;
        end
        go_idle();
    endtask

    task automatic test_blink;
        logic [3:0] exp_blank;
        req = 4'b0010;
        for (int j = 0; j < 6; j++) begin
            tick();
            exp_blank = (((j / 4) % 2) == 1) ? BL1 : 4'b0000;
            n_total++;
            if (disp_blank !== exp_blank) $display("FAIL blink1_j%0d got %b want %b", j, disp_blank, exp_blank); else n_pass++;
        end
        req = 4'b0110;
        for (int j = 0; j < 8; j++) begin
            tick();
            exp_blank = (j >= 4) ? BL2 : 4'b0000;
            n_total++;
            if (disp_blank !== exp_blank) $display("FAIL blink2_j%0d got %b want %b", j, disp_blank, exp_blank); else n_pass++;
            if (j == 0) begin
                n_total++;
                if (grant !== 4'b0100 || switch_pulse !== 1'b1)
                    $display("FAIL blink2_switch got %b/%b want 0100/1", grant, switch_pulse);
                else n_pass++;
            end
        end
        go_idle();
    endtask

    task automatic test_simultaneous;
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0100;
        tick();
        n_total++;
        if (grant !== 4'b0100) $display("FAIL sim_grant got %b want %b", grant, 4'b0100); else n_pass++;
        n_total++;
        if (switch_pulse !== 1'b1) $display("FAIL sim_pulse got %b want %b", switch_pulse, 1'b1); else n_pass++;
        n_total++;
        if (disp_bcd !== 16'h0222) $display("FAIL sim_bcd got %h want %h", disp_bcd, 16'h0222); else n_pass++;
        bcd_in[47:32] = 16'h0999;
        tick();
        n_total++;
        if (switch_pulse !== 1'b0) $display("FAIL sim_pulse_once got %b want %b", switch_pulse, 1'b0); else n_pass++;
        n_total++;
        if (disp_bcd !== 16'h0999) $display("FAIL sim_track_bcd got %h want %h", disp_bcd, 16'h0999); else n_pass++;
        go_idle();
    endtask

    initial begin
        reset    = 1'b0;
        req      = 4'b0000;
        bcd_in   = {16'h0700, 16'h0222, 16'h0105, 16'h1234};
        blink_in = {4'b0000, 4'b1100, 4'b0011, 4'b0000};
        repeat (2) tick();
        reset = 1'b1;
        tick();
        test_reset();
        test_reset_mid_hold();
        test_preemption();
        test_hold();
        test_reacquire();
        test_blink();
        test_simultaneous();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/disp_arbiter.md
# disp_arbiter

Shares the single 4-digit seven-segment display between the timekeeper's display requesters: the background clock, the date/alarm peek views, the timer/stopwatch/edit views, and the ringing alarm. It grants one requester at a time using fixed priority, preemption and a minimum hold. It registers the granted requester's BCD word and per-digit blink mask, and drives the result into the digit-scan/segment decoder.

## Interface
Parameters:
- `NREQ`, 4: number of requesters. Index 0 is the background clock; higher index means higher priority.
- `MIN_HOLD`, 50_000_000: cycles a released grantee keeps the display before it falls back. 0 means no hold.
- `BLINK_DIV`, 25_000_000: cycles per blink half-period.

Ports:
- `clk`, in, 1: system clock (100 MHz).
- `reset`, in, 1: asynchronous, active-low reset.
- `req`, in, NREQ: display request per requester. `req[0]` is ignored; requester 0 is always the fallback.
- `bcd_in`, in, 16*NREQ: 4 BCD digits per requester. Slice k is `[16k+15:16k]`, thousands in the top nibble.
- `blink_in`, in, 4*NREQ: per-digit blink enable per requester, bit 0 = ones digit.
- `grant`, out, NREQ: one-hot current owner.
- `disp_bcd`, out, 16: registered BCD word for the scan decoder.
- `disp_blank`, out, 4: per-digit blank. 1 means the digit is dark.
- `switch_pulse`, out, 1: one-cycle strobe on every change of owner.

## Operation
FSM states:
- BG: requester 0 owns the display.
- SHOW: requester k ≥ 1 owns it with `req[k]` high.
- HOLD: requester k owns it with `req[k]` low while the hold counter runs.

Winner: the highest index i ≥ 1 with `req[i]` high, evaluated every cycle.

Transitions:
- BG → SHOW(winner) whenever any `req[1..NREQ-1]` is high.
- SHOW(k) → SHOW(w) when the winner w > k (preemption, no hold).
- SHOW(k) → HOLD(k) when `req[k]` falls and no higher request is present. The hold counter loads `MIN_HOLD-1`.
- SHOW(k) with `req[k]` falling, another request present and winner w < k → HOLD(k). The lower requester waits for the hold to expire.
- HOLD(k) → SHOW(k) if `req[k]` re-asserts and no higher request is present. The counter is discarded.
- HOLD(k) → SHOW(w) immediately if w > k.
- HOLD(k) → on counter = 0: SHOW(winner) if any request is present, else BG.
- With `MIN_HOLD`=0, HOLD is skipped: SHOW(k) goes straight to the winner or BG.

Outputs:
- `disp_bcd`: each cycle, the `bcd_in` slice of the next-state owner, so data and grant change on the same edge.
- Blink phase: toggles every `BLINK_DIV` cycles. It is forced to 0 (visible) and the divider cleared on every owner change, so the edited digit is never dark on arrival.
- `disp_blank` = `blink_in` slice of the owner AND {4{phase}}. Requester 0 normally drives zero blink.
- `switch_pulse`: high for one cycle when `grant` changes. Not asserted on hold re-acquire by the same owner.

Reset (`reset` low, asynchronous):
- State BG, `grant` = 1 (bit 0 only), `disp_bcd` = 0, `disp_blank` = 0, `switch_pulse` = 0.
- Hold counter, blink divider and phase all 0.
- Reset mid-HOLD or mid-blink abandons it with no residual pulse.

## Timing
- `req` sampled at edge n → `grant`, `disp_bcd`, `disp_blank` and `switch_pulse` updated at edge n+1. Latency is one cycle and there are no combinational paths from inputs to outputs.
- Data tracking: changes on an owner's `bcd_in` appear on `disp_bcd` one cycle later while it owns the display.
- HOLD length: exactly `MIN_HOLD` cycles from the edge that registered the release to the edge that changes owner.
- Simultaneous events in the same cycle:
  - Owner release plus a higher request → direct switch to the higher requester.
  - Owner release plus re-assert on the next cycle → stays owner, no pulse.
- Counter widths: `$clog2(MIN_HOLD+1)` and `$clog2(BLINK_DIV)`. Both are cleared on wrap, with no overflow.

## Configuration
- `DISP_ARB_BLINK_EN` defined: blink divider and phase compiled in, behaving as above.
- Not defined: divider and phase are removed, `disp_blank` is tied to 0, and `blink_in` is ignored.
- Arbitration, hold and timing are identical in both builds.

## Test plan
Bench parameters: `MIN_HOLD`=10, `BLINK_DIV`=4, `DISP_ARB_BLINK_EN` defined.
- **Reset:** `reset` low mid-run with `bcd_in[15:0]`=16'h1234 → during reset, `grant`=4'b0001, `disp_bcd`=0, `disp_blank`=0; one cycle after release, `disp_bcd`=16'h1234.
- **Preemption:** `req`=4'b0010 with slice1=16'h0105, then `req[3]` rises with slice3=16'h0700 → `grant`=4'b1000 and `disp_bcd`=16'h0700 one cycle later, one `switch_pulse`, no hold.
- **Hold:** owner 2 drops `req` with `req[1]` high → `grant` stays 4'b0100 for exactly 10 cycles, then 4'b0010 with one pulse.
- **Re-acquire:** owner 2 drops `req` for 3 cycles then re-asserts → `grant` stays 4'b0100 throughout and `switch_pulse` stays 0.
- **Blink:** owner 1 with `blink_in` slice=4'b0011 → `disp_blank` = 0000 for 4 cycles then 0011 for 4 cycles, repeating; the phase restarts at visible after an owner change.
- **Simultaneous:** owner 1 drops `req` in the same cycle `req[2]` rises → `grant`=4'b0100 next cycle, single pulse, HOLD not entered.
